// File: rtl/fifo_out_sync_if.sv
// Handshake bundle for fifo_out_sync: wide write side, narrow read side, and all
// the status outputs that travel with them.
interface fifo_out_sync_if #(
    parameter int WR_DEPTH_WIDTH = 8,
    parameter int WR_DATA_WIDTH  = 256,
    parameter int RD_DEPTH_WIDTH = 11,
    parameter int RD_DATA_WIDTH  = 32
);
    logic [WR_DATA_WIDTH-1:0]  wr_data;
    logic                      wr_en;
    logic                      wr_full;
    logic [WR_DEPTH_WIDTH:0]   wr_water_level;
    logic                      almost_full;
    logic [RD_DATA_WIDTH-1:0]  rd_data;
    logic                      rd_en;
    logic                      rd_empty;
    logic [RD_DEPTH_WIDTH:0]   rd_water_level;
    logic                      almost_empty;

    modport master (
        output wr_data, wr_en, rd_en,
        input  wr_full, wr_water_level, almost_full,
        input  rd_data, rd_empty, rd_water_level, almost_empty
    );

    modport slave (
        input  wr_data, wr_en, rd_en,
        output wr_full, wr_water_level, almost_full,
        output rd_data, rd_empty, rd_water_level, almost_empty
    );
endinterface

// File: rtl/fifo_out_sync.sv
// Single-clock width-converting FIFO: wide words in, narrow slices out, low slice first.
// Define FIFOOUT_OUTPUT_REG_EN to add an output register (read latency 2 instead of 1).
module fifo_out_sync #(
    parameter int WR_DEPTH_WIDTH   = 8,
    parameter int WR_DATA_WIDTH    = 256,
    parameter int RD_DEPTH_WIDTH   = 11,
    parameter int RD_DATA_WIDTH    = 32,
    parameter int ALMOST_FULL_NUM  = 124,
    parameter int ALMOST_EMPTY_NUM = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    fifo_out_sync_if.slave bus
);
    localparam int RATIO_LOG = RD_DEPTH_WIDTH - WR_DEPTH_WIDTH;
    localparam int WR_DEPTH  = 1 << WR_DEPTH_WIDTH;
    localparam int SLICE_LOG = $clog2(RD_DATA_WIDTH);

    localparam logic [RD_DEPTH_WIDTH:0] CNT_ONE   = (RD_DEPTH_WIDTH+1)'(1);
    localparam logic [RD_DEPTH_WIDTH:0] CNT_RATIO = CNT_ONE << RATIO_LOG;
    localparam logic [WR_DEPTH_WIDTH:0] LVL_FULL  = (WR_DEPTH_WIDTH+1)'(1) << WR_DEPTH_WIDTH;
    localparam logic [WR_DEPTH_WIDTH:0] LVL_AF    = ALMOST_FULL_NUM[WR_DEPTH_WIDTH:0];
    localparam logic [RD_DEPTH_WIDTH:0] CNT_AE    = ALMOST_EMPTY_NUM[RD_DEPTH_WIDTH:0];

    logic [WR_DATA_WIDTH-1:0]  mem [WR_DEPTH];
    logic [WR_DEPTH_WIDTH-1:0] wr_ptr;
    logic [RD_DEPTH_WIDTH-1:0] rd_ptr;
    logic [RD_DEPTH_WIDTH:0]   count, count_next;
    logic [WR_DEPTH_WIDTH:0]   wr_level_next;
    logic                      wr_accept, rd_accept;
    logic [WR_DATA_WIDTH-1:0]  rd_word;
    logic [RD_DATA_WIDTH-1:0]  rd_slice;
    logic [RD_DATA_WIDTH-1:0]  rd_q;

    assign wr_accept = bus.wr_en && !bus.wr_full;
    assign rd_accept = bus.rd_en && !bus.rd_empty;

    // rd_ptr counts narrow words: upper bits pick the RAM row, lower bits the slice.
    assign rd_word  = mem[rd_ptr[RD_DEPTH_WIDTH-1:RATIO_LOG]];
    assign rd_slice = rd_word[{rd_ptr[RATIO_LOG-1:0], {SLICE_LOG{1'b0}}} +: RD_DATA_WIDTH];

    // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_next = count;
        unique case ({wr_accept, rd_accept})
            2'b10:   count_next = count + CNT_RATIO;
            2'b01:   count_next = count - CNT_ONE;
            2'b11:   count_next = count + CNT_RATIO - CNT_ONE;
            default: count_next = count;
        endcase
        // A partially drained write row still occupies a whole row.
        wr_level_next = count_next[RD_DEPTH_WIDTH:RATIO_LOG]
                      + {{WR_DEPTH_WIDTH{1'b0}}, |count_next[RATIO_LOG-1:0]};
    end

    // NOTE: the RAM array has no reset; clearing pointers and count is enough to discard contents.
    always_ff @(posedge clk) begin
        if (wr_accept) mem[wr_ptr] <= bus.wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            rd_q               <= '0;
            bus.wr_full        <= 1'b0;
            bus.almost_full    <= 1'b0;
            bus.wr_water_level <= '0;
            bus.rd_empty       <= 1'b1;
            bus.almost_empty   <= 1'b1;
            bus.rd_water_level <= '0;
        end else begin
            if (wr_accept) wr_ptr <= wr_ptr + 1'b1;
            if (rd_accept) begin
                rd_ptr <= rd_ptr + 1'b1;
                rd_q   <= rd_slice;
            end
            count              <= count_next;
            bus.wr_full        <= (wr_level_next == LVL_FULL);
            bus.almost_full    <= (wr_level_next >= LVL_AF);
            bus.wr_water_level <= wr_level_next;
            bus.rd_empty       <= (count_next == '0);
            bus.almost_empty   <= (count_next <= CNT_AE);
            bus.rd_water_level <= count_next;
        end
    end

`ifdef FIFOOUT_OUTPUT_REG_EN
    logic [RD_DATA_WIDTH-1:0] out_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_q <= '0;
        else        out_q <= rd_q;
    end

    assign bus.rd_data = out_q;
`else
    assign bus.rd_data = rd_q;
`endif
endmodule

// File: tb/tb_fifo_out_sync.sv
// Scoreboard bench for fifo_out_sync: a count model predicts flags and levels, and a
// slice queue predicts rd_data, checked every cycle including hold cycles.
module tb_fifo_out_sync;
`ifdef FIFOOUT_OUTPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_out_sync_if bus ();

    fifo_out_sync dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    int          mc    = 0;
    int          cyc   = 0;
    logic [31:0] slice_q [$];
    logic [31:0] pend_d  [$];
    int          pend_t  [$];
    logic [31:0] hold    = '0;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int ceil_lvl(input int c);
        return (c + 7) / 8;
    endfunction

    task automatic check_state();
        check("rd_water_level", 256'(bus.rd_water_level), 256'(mc));
        check("wr_water_level", 256'(bus.wr_water_level), 256'(ceil_lvl(mc)));
        check("wr_full",        256'(bus.wr_full),        256'(ceil_lvl(mc) == 256));
        check("almost_full",    256'(bus.almost_full),    256'(ceil_lvl(mc) >= 124));
        check("rd_empty",       256'(bus.rd_empty),       256'(mc == 0));
        check("almost_empty",   256'(bus.almost_empty),   256'(mc <= 4));
        check("rd_data",        256'(bus.rd_data),        256'(hold));
    endtask

    // One clock: drive, predict acceptance from the model, advance, then check #1 after the edge.
    task automatic cycle(input logic we, input logic [255:0] wd, input logic re);
        bit wr_ok, rd_ok;
        bus.wr_en   = we;
        bus.wr_data = wd;
        bus.rd_en   = re;
        wr_ok = we && (ceil_lvl(mc) < 256);
        rd_ok = re && (mc > 0);
        @(posedge clk);
        cyc++;
        if (rd_ok) begin
            pend_d.push_back(slice_q.pop_front());
            pend_t.push_back(cyc + LAT - 1);
        end
        if (wr_ok) for (int i = 0; i < 8; i++) slice_q.push_back(wd[i*32 +: 32]);
        mc = mc + (wr_ok ? 8 : 0) - (rd_ok ? 1 : 0);
        if (pend_t.size() > 0 && pend_t[0] == cyc) begin
            hold = pend_d.pop_front();
            void'(pend_t.pop_front());
        end
        #1;
        check_state();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [255:0] w;

        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = '0;

        // Reset values, checked while reset is held.
        #12;
        check_state();
        #1 rst_n = 1'b1;

        // Fill: 257 writes of a decrementing pattern; the last one is refused.
        for (int k = 0; k < 257; k++) cycle(1'b1, '1 - 256'(k), 1'b0);
        idle(1);

        // Drain from full with one extra read while empty.
        for (int k = 0; k < 2049; k++) cycle(1'b0, '0, 1'b1);
        idle(LAT + 1);

        // Slice order: slice i holds value i.
        w = '0;
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = 32'(i);
        cycle(1'b1, w, 1'b0);
        for (int k = 0; k < 8; k++) cycle(1'b0, '0, 1'b1);
        idle(LAT + 1);

        // Concurrent read and write with three words already stored.
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
            cycle(1'b1, w, 1'b0);
        end
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 8; i++) w[i*32 +: 32] = $urandom;
            cycle(1'b1, w, 1'b1);
        end
        for (int k = 0; k < 59; k++) cycle(1'b0, '0, 1'b1);
        idle(LAT + 1);

        // Asynchronous reset in the middle of a mixed burst.
        for (int k = 0; k < 4; k++) cycle(1'b1, {8{32'hA5A5_0000 + 32'(k)}}, 1'b0);
        for (int k = 0; k < 3; k++) cycle(1'b1, {8{32'h5A5A_0000 + 32'(k)}}, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        mc   = 0;
        hold = '0;
        slice_q.delete();
        pend_d.delete();
        pend_t.delete();
        check_state();
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        check_state();

        // After reset: traffic starts from empty.
        for (int i = 0; i < 8; i++) w[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        cycle(1'b1, w, 1'b0);
        for (int k = 0; k < 9; k++) cycle(1'b0, '0, 1'b1);
        idle(LAT + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
